// File: rtl/mm_loop_sched.sv
// mm_loop_sched: stallable, abortable three-level (i, j, k) loop-nest index sequencer.
module mm_loop_sched #(
  parameter int SIZE = 12
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic            abort,
  input  logic [SIZE-1:0] rows,
  input  logic [SIZE-1:0] cols,
  input  logic [SIZE-1:0] inner,
  output logic            busy,
  output logic            done,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [SIZE-1:0] idx_i,
  output logic [SIZE-1:0] idx_j,
  output logic [SIZE-1:0] idx_k,
  output logic            k_first,
  output logic            k_last,
  output logic            nest_last
);
  // State encoding doubles as the busy/done/m_valid flops.
  typedef enum logic [2:0] {IDLE = 3'b000, RUN = 3'b101, DONE = 3'b110} state_t;
  state_t state, state_n;
  logic [SIZE-1:0] dim_r, dim_c, dim_k, dim_r_n, dim_c_n, dim_k_n, i_n, j_n, k_n;
  logic k_end, j_end, i_end, zero;
  assign busy      = state[2];
  assign done      = state[1];
  assign m_valid   = state[0];
  assign k_end     = idx_k == dim_k - SIZE'(1);
  assign j_end     = idx_j == dim_c - SIZE'(1);
  assign i_end     = idx_i == dim_r - SIZE'(1);
  assign k_first   = m_valid && idx_k == '0;
  assign k_last    = m_valid && k_end;
  assign nest_last = k_last && j_end && i_end;
  assign zero      = rows == '0 || cols == '0 || inner == '0;
  always_comb begin
    state_n = state;
    dim_r_n = dim_r;
    dim_c_n = dim_c;
    dim_k_n = dim_k;
    i_n     = idx_i;
    j_n     = idx_j;
    k_n     = idx_k;
    if (abort) begin
      state_n = IDLE;
      i_n     = '0;
      j_n     = '0;
      k_n     = '0;
    end else if (state == IDLE) begin
      if (start) begin
        state_n = zero ? DONE : RUN;
        dim_r_n = rows;
        dim_c_n = cols;
        dim_k_n = inner;
        i_n     = '0;
        j_n     = '0;
        k_n     = '0;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end else if (m_ready) begin
      // Final beat wraps every index back to 0 on its way to DONE.
      k_n     = k_end ? '0 : idx_k + SIZE'(1);
      j_n     = k_end ? (j_end ? '0 : idx_j + SIZE'(1)) : idx_j;
      i_n     = (k_end && j_end) ? (i_end ? '0 : idx_i + SIZE'(1)) : idx_i;
      state_n = nest_last ? DONE : RUN;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      dim_r <= '0;
      dim_c <= '0;
      dim_k <= '0;
      idx_i <= '0;
      idx_j <= '0;
      idx_k <= '0;
    end else begin
      state <= state_n;
      dim_r <= dim_r_n;
      dim_c <= dim_c_n;
      dim_k <= dim_k_n;
      idx_i <= i_n;
      idx_j <= j_n;
      idx_k <= k_n;
    end
  end
endmodule

// File: tb/tb_mm_loop_sched.sv
// tb_mm_loop_sched: directed scenario checks for the mm_loop_sched loop-nest sequencer.
module tb_mm_loop_sched;
  logic aclk = 0, aresetn = 0, start = 0, abort = 0, m_ready = 0;
  logic [11:0] rows = 0, cols = 0, inner = 0;
  logic busy, done, m_valid, k_first, k_last, nest_last;
  logic [11:0] idx_i, idx_j, idx_k;
  int n_cmp = 0, n_err = 0;
  logic [39:0] got, exp;

  mm_loop_sched #(.SIZE(12)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .rows(rows), .cols(cols), .inner(inner),
    .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
    .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
    .k_first(k_first), .k_last(k_last), .nest_last(nest_last)
  );

  always #5 aclk = ~aclk;

  assign got = {m_valid, idx_i, idx_j, idx_k, k_first, k_last, nest_last};

  task automatic start_nest(input int r, input int c, input int kk);
    @(negedge aclk);
    rows  = 12'(r);
    cols  = 12'(c);
    inner = 12'(kk);
    start = 1;
    @(negedge aclk);
    start = 0;
  endtask

  task automatic test_reset();
    aresetn = 0;
    repeat (2) @(negedge aclk);
    n_cmp++;
    if ({busy, done, got} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", {busy, done, got});
    end
    aresetn = 1;
  endtask

  task automatic test_nest(input int r, input int c, input int kk, input string nm);
    int nf = 0, nl = 0;
    m_ready = 1;
    start_nest(r, c, kk);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        for (int k = 0; k < kk; k++) begin
          exp = {1'b1, 12'(i), 12'(j), 12'(k), k == 0, k == kk - 1,
                 i == r - 1 && j == c - 1 && k == kk - 1};
          n_cmp++;
          if (got !== exp) begin
            n_err++;
            $display("FAIL %s beat(%0d,%0d,%0d): got %h want %h", nm, i, j, k, got, exp);
          end
          nf += int'(k_first);
          nl += int'(k_last);
          @(negedge aclk);
        end
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL %s done_cycle: got %b want 110", nm, {busy, done, m_valid});
    end
    @(negedge aclk);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL %s idle_after: got %b want 000", nm, {busy, done, m_valid});
    end
    n_cmp++;
    if (nf != r * c || nl != r * c) begin
      n_err++;
      $display("FAIL %s flag_counts: got first=%0d last=%0d want %0d", nm, nf, nl, r * c);
    end
  endtask

  task automatic test_stall();
    m_ready = 0;
    start_nest(2, 3, 4);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 4; k++) begin
          int n = 0;
          exp = {1'b1, 12'(i), 12'(j), 12'(k), k == 0, k == 3, i == 1 && j == 2 && k == 3};
          do begin
            n_cmp++;
            if (got !== exp) begin
              n_err++;
              $display("FAIL stall beat(%0d,%0d,%0d) wait %0d: got %h want %h", i, j, k, n, got, exp);
            end
            m_ready = (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge aclk);
            n++;
          end while (!m_ready);
        end
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL stall_done: got %b want 110", {busy, done, m_valid});
    end
    @(negedge aclk);
  endtask

  task automatic test_zero();
    m_ready = 1;
    start_nest(2, 0, 4);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL zero_done: got %b want 110", {busy, done, m_valid});
    end
    @(negedge aclk);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL zero_idle: got %b want 000", {busy, done, m_valid});
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    m_ready = 1;
    start_nest(2, 3, 4);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 4; k++) begin
          exp = {1'b1, 12'(i), 12'(j), 12'(k), k == 0, k == 3, i == 1 && j == 2 && k == 3};
          n_cmp++;
          if (got !== exp) begin
            n_err++;
            $display("FAIL start_ignored beat(%0d,%0d,%0d): got %h want %h", i, j, k, got, exp);
          end
          start = (n == 5);
          if (n == 5) {rows, cols, inner} = {12'd1, 12'd1, 12'd1};
          n++;
          @(negedge aclk);
        end
    start = 0;
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL start_ignored_done: got %b want 110", {busy, done, m_valid});
    end
    @(negedge aclk);
  endtask

  task automatic test_abort();
    m_ready = 1;
    start_nest(2, 3, 4);
    repeat (10) @(negedge aclk);
    n_cmp++;
    if (got !== {1'b1, 12'd0, 12'd2, 12'd2, 3'b000}) begin
      n_err++;
      $display("FAIL abort_pre: got %h want tuple (0,2,2)", got);
    end
    abort = 1;
    @(negedge aclk);
    abort = 0;
    n_cmp++;
    if ({busy, done, got} !== 42'd0) begin
      n_err++;
      $display("FAIL abort_idle: got %h want 0", {busy, done, got});
    end
    @(negedge aclk);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_no_done: got %b want 000", {busy, done, m_valid});
    end
    test_nest(2, 3, 4, "after_abort");
  endtask

  task automatic test_async_reset();
    m_ready = 1;
    start_nest(2, 3, 4);
    repeat (18) @(negedge aclk);
    n_cmp++;
    if (got !== {1'b1, 12'd1, 12'd1, 12'd2, 3'b000}) begin
      n_err++;
      $display("FAIL areset_pre: got %h want tuple (1,1,2)", got);
    end
    #2 aresetn = 0;
    #1;
    n_cmp++;
    if ({busy, done, got} !== 42'd0) begin
      n_err++;
      $display("FAIL areset_async: got %h want 0", {busy, done, got});
    end
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    n_cmp++;
    if ({busy, done, got} !== 42'd0) begin
      n_err++;
      $display("FAIL areset_idle: got %h want 0", {busy, done, got});
    end
    test_nest(4095, 1, 2, "max_dims");
  endtask

  initial begin
    test_reset();
    test_nest(2, 3, 4, "full");
    test_stall();
    test_nest(1, 1, 1, "single");
    test_zero();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
